ps2_command_sender: RTL and testbench
=====================================

// Module: ps2_command_sender
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED LED set, 0xFF reset)
//  to the keyboard over the shared PS2_CLK/PS2_DAT lines and reports device ACK or failure.
//  Sits beside PS2_Controller under KeyCompiler-style tops; the top drives the pads open-drain:
//  PS2_CLK = clk_oe ? 1'b0 : 1'bz; PS2_DAT = dat_oe ? 1'b0 : 1'bz.
// PARAMETERS
//  INHIBIT_CYCLES  6000    clock-low inhibit before request (120 us @ 50 MHz)
//  FIRST_TIMEOUT   750000  max cycles from request to first device falling edge (15 ms)
//  BIT_TIMEOUT     100000  max cycles between consecutive device falling edges (2 ms)
// PORTS
//  CLOCK_50    in   1  system clock, 50 MHz
//  reset       in   1  synchronous, active-high
//  cmd_data    in   8  byte to send; sampled when cmd_send accepted
//  cmd_send    in   1  request strobe; accepted only while busy=0
//  ps2_clk_in  in   1  raw PS2_CLK pad level (asynchronous)
//  ps2_dat_in  in   1  raw PS2_DAT pad level (asynchronous)
//  clk_oe      out  1  1 = pull PS2_CLK low
//  dat_oe      out  1  1 = pull PS2_DAT low
//  busy        out  1  high from acceptance until done/error pulse cycle inclusive
//  cmd_done    out  1  one-cycle pulse: byte sent and ACK seen
//  cmd_error   out  1  one-cycle pulse: timeout or missing ACK
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0; reset wins over every other event.
//  Inputs pass a 2-FF synchronizer; fall = prev & ~cur on synced clock (3-cycle detect latency).
//  All outputs registered. dat_oe drives bit b as dat_oe = ~b (0 driven, 1 released).
//  States / transitions:
//   IDLE     : oe=0. cmd_send -> latch byte, parity = ~^cmd_data (odd), busy=1 next cycle -> INHIBIT.
//   INHIBIT  : clk_oe=1 for INHIBIT_CYCLES cycles -> REQ.
//   REQ      : dat_oe=1 (start bit), clk_oe=0 same cycle; wait fall; timeout FIRST_TIMEOUT -> ERR.
//   SHIFT    : on each fall k=1..8 present data bit k-1 (LSB first); fall 9 -> parity;
//              fall 10 -> stop (dat_oe=0). bit_cnt 4-bit, counts falls 1..11.
//   ACK      : on fall 11 sample synced data: 0 -> WAIT_IDLE, 1 -> ERR.
//   WAIT_IDLE: wait synced clk=1 and dat=1 -> DONE. Subject to BIT_TIMEOUT.
//   DONE     : cmd_done=1 one cycle -> IDLE.   ERR: cmd_error=1 one cycle, oe=0 -> IDLE.
//  BIT_TIMEOUT counter clears on every fall; expiry in SHIFT/ACK/WAIT_IDLE -> ERR.
//  Line changes take effect the cycle after fall detection (well inside device low phase).
//  cmd_send while busy=1 ignored (no queue); cmd_send in DONE/ERR cycle ignored.
//  cmd_done and cmd_error never assert together; exactly one per accepted command.
//  Reset mid-operation: next edge clk_oe=dat_oe=0, no done/error pulse; device times out itself.
//  Falls during IDLE/INHIBIT (device traffic) ignored; no error raised.
// STRUCTURE
//  ps2_pkg: state encoding localparams (IDLE..ERR), bit-slot constants (START=0, PARITY=9,
//   STOP=10, ACK=11), default timing constants shared with receiver-side blocks.
//  Sub-module ps2_line_sync: 2-FF synchronizer + falling-edge detector, one instance per line
//   (fall output unused for data line).
//  Top wiring: busy gates PS2_Controller received_data_en so echoed bits are not decoded.
// TESTING  (bench uses INHIBIT_CYCLES=20, FIRST_TIMEOUT=200, BIT_TIMEOUT=100; device model
//  clocks 11 falls, 10-cycle half period, samples on rising edge)
//  1 send 0xED -> clk low 20 cycles; model captures start 0, bits 1,0,1,1,0,1,1,1, parity 1,
//    stop 1; model ACKs -> cmd_done pulse once, busy falls, oe both 0.
//  2 send 0x01 -> parity 0; 0x00 -> parity 1; 0xFF -> parity 1; each cmd_done.
//  3 model never clocks after request -> cmd_error at 200 cycles after REQ, lines released.
//  4 model stops after 5 falls -> cmd_error 100 cycles after last fall; model leaves data
//    high at fall 11 -> cmd_error, no cmd_done.
//  5 cmd_send pulsed again mid-SHIFT with 0x55 -> ignored, original byte completes intact.
//  6 reset asserted during SHIFT -> next cycle clk_oe=dat_oe=busy=0, no pulses; fresh
//    cmd_send 0xF4 afterwards completes with cmd_done.

Source files
------------

// File: rtl/ps2_command_sender_pkg.sv
// Shared PS/2 host-transmit definitions: FSM states, frame slot numbers, default timing.
package ps2_command_sender_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_ERR
  } state_t;

  // Frame slot numbers, indexed by device falling-edge count
  localparam int unsigned SLOT_START  = 0;
  localparam int unsigned SLOT_PARITY = 9;
  localparam int unsigned SLOT_STOP   = 10;
  localparam int unsigned SLOT_ACK    = 11;

  localparam int unsigned BIT_CNT_W = 4;
  localparam int unsigned FRAME_W   = 9;

  // 50 MHz defaults, also used by receiver-side blocks
  localparam int unsigned DEF_INHIBIT_CYCLES = 6000;
  localparam int unsigned DEF_FIRST_TIMEOUT  = 750000;
  localparam int unsigned DEF_BIT_TIMEOUT    = 100000;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_command_sender_line_sync.sv
// Two-flop synchronizer for one PS/2 pad plus a falling-edge detector on the synced level.
module ps2_command_sender_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall_c
);

  logic meta;
  logic prev;

  // Reset to the idle-high line level so no spurious fall appears after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= line;
      level <= meta;
      prev  <= level;
    end
  end

  assign fall_c = prev & ~level;

endmodule

// File: rtl/ps2_command_sender.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clock out 8 data bits,
// odd parity and stop on device clock falls, then check the device ACK.
module ps2_command_sender
  import ps2_command_sender_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned FIRST_TIMEOUT  = DEF_FIRST_TIMEOUT,
  parameter int unsigned BIT_TIMEOUT    = DEF_BIT_TIMEOUT
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_send,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       clk_oe,
  output logic       dat_oe,
  output logic       busy,
  output logic       cmd_done,
  output logic       cmd_error
);

  localparam int unsigned MAX_TO = (FIRST_TIMEOUT > BIT_TIMEOUT) ? FIRST_TIMEOUT : BIT_TIMEOUT;
  localparam int unsigned MAX_T  = (MAX_TO > INHIBIT_CYCLES) ? MAX_TO : INHIBIT_CYCLES;
  localparam int unsigned CNT_W  = (MAX_T > 2) ? $clog2(MAX_T) : 1;

  logic clk_sync, clk_fall, dat_sync, dat_fall_unused;

  ps2_command_sender_line_sync u_clk_sync (
    .clk    (CLOCK_50),
    .reset  (reset),
    .line   (ps2_clk_in),
    .level  (clk_sync),
    .fall_c (clk_fall)
  );

  ps2_command_sender_line_sync u_dat_sync (
    .clk    (CLOCK_50),
    .reset  (reset),
    .line   (ps2_dat_in),
    .level  (dat_sync),
    .fall_c (dat_fall_unused)
  );

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_d;
  logic [FRAME_W-1:0]   sh, sh_d;
  logic                 clk_oe_d, dat_oe_d, busy_d, done_d, error_d;
  logic                 go_err, timeout_c;

  assign timeout_c = (state == S_REQ) ? (cnt == CNT_W'(FIRST_TIMEOUT - 1))
                                      : (cnt == CNT_W'(BIT_TIMEOUT - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      clk_oe    <= 1'b0;
      dat_oe    <= 1'b0;
      busy      <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_error <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bit_cnt   <= bit_cnt_d;
      sh        <= sh_d;
      clk_oe    <= clk_oe_d;
      dat_oe    <= dat_oe_d;
      busy      <= busy_d;
      cmd_done  <= done_d;
      cmd_error <= error_d;
    end
  end

  // Next state and next registered outputs; sh holds {parity, data} and shifts out LSB first
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CNT_W'(1);
    bit_cnt_d = bit_cnt;
    sh_d      = sh;
    clk_oe_d  = clk_oe;
    dat_oe_d  = dat_oe;
    busy_d    = busy;
    done_d    = 1'b0;
    error_d   = 1'b0;
    go_err    = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_d    = '0;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        if (cmd_send) begin
          sh_d      = {odd_parity(cmd_data), cmd_data};
          bit_cnt_d = BIT_CNT_W'(SLOT_START);
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_d    = '0;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          state_d  = S_REQ;
        end
      end

      // Each device fall presents the next slot: data 1..8, parity 9, released stop 10
      S_REQ, S_SHIFT: begin
        if (clk_fall) begin
          bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
          cnt_d     = '0;
          sh_d      = {1'b1, sh[FRAME_W-1:1]};
          dat_oe_d  = (bit_cnt_d <= BIT_CNT_W'(SLOT_PARITY)) ? ~sh[0] : 1'b0;
          state_d   = (bit_cnt_d == BIT_CNT_W'(SLOT_STOP)) ? S_ACK : S_SHIFT;
        end else if (timeout_c) begin
          go_err = 1'b1;
        end
      end

      S_ACK: begin
        if (clk_fall) begin
          bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
          cnt_d     = '0;
          if (!dat_sync && bit_cnt_d == BIT_CNT_W'(SLOT_ACK)) begin
            state_d = S_WAIT_IDLE;
          end else begin
            go_err = 1'b1;
          end
        end else if (timeout_c) begin
          go_err = 1'b1;
        end
      end

      S_WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (clk_fall) begin
          cnt_d = '0;
        end else if (timeout_c) begin
          go_err = 1'b1;
        end
      end

      S_DONE, S_ERR: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (go_err) begin
      state_d  = S_ERR;
      error_d  = 1'b1;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_command_sender.sv
// Randomized bench: a PS/2 device model clocks frames out of the sender and is checked
// against a frame/timing reference computed from byte value and protocol timing.
module tb_ps2_command_sender;

  localparam int unsigned INH  = 20;
  localparam int unsigned FT   = 200;
  localparam int unsigned BT   = 100;
  localparam int unsigned HALF = 10;
  localparam int unsigned DETECT_LAT = 3;

  logic       clk;
  logic       reset;
  logic [7:0] cmd_data;
  logic       cmd_send;
  logic       clk_oe, dat_oe, busy, cmd_done, cmd_error;
  logic       dev_clk, dev_dat;
  logic       clk_line, dat_line;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int err_cyc = 0, req_cyc = 0, inh_cyc = 0, last_fall_cyc = 0;
  logic prev_err = 1'b0, prev_clk_oe = 1'b0;
  logic [10:0] junk_frame;
  int d0, e0;

  // Open-drain pads: either side may pull low
  assign clk_line = ~clk_oe & dev_clk;
  assign dat_line = ~dat_oe & dev_dat;

  ps2_command_sender #(
    .INHIBIT_CYCLES (INH),
    .FIRST_TIMEOUT  (FT),
    .BIT_TIMEOUT    (BT)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .cmd_data   (cmd_data),
    .cmd_send   (cmd_send),
    .ps2_clk_in (clk_line),
    .ps2_dat_in (dat_line),
    .clk_oe     (clk_oe),
    .dat_oe     (dat_oe),
    .busy       (busy),
    .cmd_done   (cmd_done),
    .cmd_error  (cmd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and event timestamps (cyc = index of the edge that produced the value)
  always @(negedge clk) begin
    if (cmd_done) done_cnt++;
    if (cmd_error) begin
      err_cnt++;
      if (!prev_err) err_cyc = cyc;
    end
    if (cmd_done && cmd_error) both_cnt++;
    if (clk_oe && !prev_clk_oe) inh_cyc = cyc;
    if (!clk_oe && prev_clk_oe && dat_oe) req_cyc = cyc;
    prev_err    = cmd_error;
    prev_clk_oe = clk_oe;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1
  function automatic logic [10:0] frame_model(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic wait_req();
    int n;
    n = 0;
    while (!(dat_oe && !clk_oe) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("request_seen", 32'(n < 1000), 32'd1);
  endtask

  task automatic send(input logic [7:0] d);
    cmd_data = d;
    cmd_send = 1'b1;
    @(negedge clk);
    cmd_send = 1'b0;
    cmd_data = 8'($urandom);
    chk("busy_on_accept", 32'(busy), 32'd1);
  endtask

  // Device model: generates nfalls clock pulses, samples data on each rising edge
  task automatic dev_run(input int nfalls, input bit ack_ok, output logic [10:0] frame);
    frame = '0;
    wait_req();
    repeat ($urandom_range(1, 30)) @(negedge clk);
    frame[0] = dat_line;
    for (int k = 1; k <= nfalls; k++) begin
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      if (k <= 10) frame[4'(k)] = dat_line;
      dev_clk = 1'b1;
      if (k == 10 && ack_ok) dev_dat = 1'b0;
      if (k == 11) dev_dat = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_dat = 1'b1;
  endtask

  task automatic run_cmd(input logic [7:0] d, input int nfalls, input bit ack_ok, input bit inject);
    int n, dd, ee;
    logic [10:0] frame;
    bit exp_done;
    exp_done = (nfalls >= 11) && ack_ok;
    dd = done_cnt;
    ee = err_cnt;
    send(d);
    fork
      dev_run(nfalls, ack_ok, frame);
      if (inject) begin
        wait_req();
        repeat (70) @(negedge clk);
        cmd_data = 8'h55;
        cmd_send = 1'b1;
        @(negedge clk);
        cmd_send = 1'b0;
      end
    join
    n = 0;
    while (done_cnt == dd && err_cnt == ee && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("response_seen", 32'(n < 2000), 32'd1);
    repeat (4) @(negedge clk);
    chk("done_count", 32'(done_cnt - dd), 32'(exp_done));
    chk("error_count", 32'(err_cnt - ee), 32'(!exp_done));
    chk("busy_after", 32'(busy), 32'd0);
    chk("clk_oe_after", 32'(clk_oe), 32'd0);
    chk("dat_oe_after", 32'(dat_oe), 32'd0);
    if (exp_done) begin
      chk("frame", 32'(frame), 32'(frame_model(d)));
      chk("inhibit_len", 32'(req_cyc - inh_cyc), 32'(INH));
    end else if (nfalls == 0) begin
      chk("first_timeout", 32'(err_cyc - req_cyc), 32'(FT));
    end else if (nfalls < 11) begin
      chk("bit_timeout", 32'(err_cyc - last_fall_cyc), 32'(BT + DETECT_LAT));
    end
  endtask

  initial begin
    reset    = 1'b1;
    cmd_send = 1'b0;
    cmd_data = 8'h00;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", 32'(clk_oe), 32'd0);
    chk("rst_dat_oe", 32'(dat_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(cmd_done), 32'd0);
    chk("rst_error", 32'(cmd_error), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    run_cmd(8'hED, 11, 1'b1, 1'b0);
    run_cmd(8'h01, 11, 1'b1, 1'b0);
    run_cmd(8'h00, 11, 1'b1, 1'b0);
    run_cmd(8'hFF, 11, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) run_cmd(8'($urandom), 11, 1'b1, 1'b0);

    run_cmd(8'($urandom), 0, 1'b1, 1'b0);
    run_cmd(8'($urandom), 5, 1'b1, 1'b0);
    run_cmd(8'($urandom_range(1, 9)), int'($urandom_range(1, 9)), 1'b1, 1'b0);
    run_cmd(8'($urandom), 11, 1'b0, 1'b0);
    run_cmd(8'hED, 11, 1'b1, 1'b1);
    run_cmd(8'h3C, 11, 1'b1, 1'b1);

    // Reset in the middle of a frame
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hA5);
    fork
      dev_run(11, 1'b1, junk_frame);
      begin
        wait_req();
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_clk_oe", 32'(clk_oe), 32'd0);
        chk("midrst_dat_oe", 32'(dat_oe), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_pulses", 32'(cmd_done | cmd_error), 32'd0);
        reset = 1'b0;
      end
    join
    repeat (300) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_no_error", 32'(err_cnt - e0), 32'd0);
    run_cmd(8'hF4, 11, 1'b1, 1'b0);

    chk("done_error_exclusive", 32'(both_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
